// File: rtl/exec_commit_arbiter_pkg.sv
// Shared definitions for the execution-result commit arbiter: default sizes,
// payload alias and the source-index width helper.
package exec_commit_arbiter_pkg;

  localparam int DEF_NUM_SRC   = 6;
  localparam int DEF_NUM_PORT  = 3;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_PAYLOAD_W = 96;

  typedef logic [DEF_PAYLOAD_W-1:0] payload_t;

  // A single source still needs a 1-bit index field on the commit ports.
  function automatic int src_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exec_result_fifo.sv
// Single-source result FIFO with registered occupancy; flush empties it and
// wins over any same-cycle push or pop.
module exec_result_fifo #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 96,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic [PAYLOAD_W-1:0] push_data,
  input  logic                 pop,
  output logic [PAYLOAD_W-1:0] head_data,
  output logic [CNT_W-1:0]     count,
  output logic                 ready,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign ready     = (count < CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && ready && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/exec_commit_arbiter.sv
// Per-source result FIFOs feeding a round-robin, compacting commit arbiter.
// Optional EXEC_ARB_BYPASS_EN lets an empty source's live input be granted same-cycle.
module exec_commit_arbiter
  import exec_commit_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int NUM_PORT  = DEF_NUM_PORT,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic [NUM_SRC-1:0]                       src_valid,
  output logic [NUM_SRC-1:0]                       src_ready,
  input  logic [NUM_SRC*PAYLOAD_W-1:0]             src_data,
  input  logic                                     commit_ready,
  output logic [NUM_PORT-1:0]                      commit_valid,
  output logic [NUM_PORT*PAYLOAD_W-1:0]            commit_data,
  output logic [NUM_PORT*src_id_w(NUM_SRC)-1:0]    commit_src,
  output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]       fifo_count
);

  localparam int SRC_W = src_id_w(NUM_SRC);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_SRC-1:0]   empty;
  logic [NUM_SRC-1:0]   elig;
  logic [NUM_SRC-1:0]   grant;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   pop;
  logic [PAYLOAD_W-1:0] head_data [NUM_SRC];
  logic [PAYLOAD_W-1:0] cand_data [NUM_SRC];
  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     rr_nxt;
  logic [SRC_W-1:0]     last_src;
  logic                 any_grant;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    exec_result_fifo #(
      .DEPTH     (DEPTH),
      .PAYLOAD_W (PAYLOAD_W),
      .CNT_W     (CNT_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (push[i]),
      .push_data (src_data[i*PAYLOAD_W +: PAYLOAD_W]),
      .pop       (pop[i]),
      .head_data (head_data[i]),
      .count     (fifo_count[i*CNT_W +: CNT_W]),
      .ready     (src_ready[i]),
      .empty     (empty[i])
    );

`ifdef EXEC_ARB_BYPASS_EN
    // A bypassed result that commits this cycle must not also be buffered.
    assign elig[i]      = reset && !flush && (!empty[i] || src_valid[i]);
    assign cand_data[i] = empty[i] ? src_data[i*PAYLOAD_W +: PAYLOAD_W] : head_data[i];
    assign push[i]      = src_valid[i] && !(empty[i] && grant[i] && commit_ready);
`else
    assign elig[i]      = reset && !flush && !empty[i];
    assign cand_data[i] = head_data[i];
    assign push[i]      = src_valid[i];
`endif
    assign pop[i] = grant[i] && commit_ready && !empty[i];
  end

  // Scan sources starting at rr_ptr; the n-th eligible one lands on port n.
  always_comb begin
    logic [SRC_W:0] sel;
    int             n;
    sel          = '0;
    n            = 0;
    grant        = '0;
    commit_valid = '0;
    commit_data  = '0;
    commit_src   = '0;
    last_src     = '0;
    any_grant    = 1'b0;
    for (int off = 0; off < NUM_SRC; off++) begin
      sel = {1'b0, rr_ptr} + (SRC_W+1)'(off);
      if (sel >= (SRC_W+1)'(NUM_SRC)) sel = sel - (SRC_W+1)'(NUM_SRC);
      for (int s = 0; s < NUM_SRC; s++) begin
        if ((sel[SRC_W-1:0] == SRC_W'(s)) && elig[s] && (n < NUM_PORT)) begin
          grant[s]  = 1'b1;
          last_src  = SRC_W'(s);
          any_grant = 1'b1;
          for (int p = 0; p < NUM_PORT; p++) begin
            if (p == n) begin
              commit_valid[p]                     = 1'b1;
              commit_data[p*PAYLOAD_W +: PAYLOAD_W] = cand_data[s];
              commit_src[p*SRC_W +: SRC_W]         = SRC_W'(s);
            end
          end
          n = n + 1;
        end
      end
    end
  end

  always_comb begin
    rr_nxt = rr_ptr;
    if (commit_ready && any_grant)
      rr_nxt = (last_src == SRC_W'(NUM_SRC - 1)) ? '0 : last_src + SRC_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rr_ptr <= '0;
    else if (flush) rr_ptr <= '0;
    else            rr_ptr <= rr_nxt;
  end

endmodule

// File: tb/tb_exec_commit_arbiter.sv
// Directed scoreboard bench for exec_commit_arbiter (default build; the
// EXEC_ARB_BYPASS_EN build runs the same-cycle bypass scenario instead).
module tb_exec_commit_arbiter;
  import exec_commit_arbiter_pkg::*;

  localparam int NS = 6;
  localparam int NP = 3;
  localparam int PW = 96;
  localparam int SW = 3;
  localparam int CW = 3;

  typedef struct packed {
    logic [SW-1:0] src;
    payload_t      data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS*PW-1:0] src_data;
  logic             commit_ready;
  logic [NP-1:0]    commit_valid;
  logic [NP*PW-1:0] commit_data;
  logic [NP*SW-1:0] commit_src;
  logic [NS*CW-1:0] fifo_count;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  exec_commit_arbiter #(
    .NUM_SRC(NS), .NUM_PORT(NP), .DEPTH(4), .PAYLOAD_W(PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_data     (src_data),
    .commit_ready (commit_ready),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .commit_src   (commit_src),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic payload_t mk(input int s, input int q);
    return {8'(s), 8'(q), 80'hC0FFEE123456789ABCDE};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one source and, when it is expected to commit, record it.
  task automatic drive(input int s, input int q, input bit expect_commit);
    src_valid[s]             = 1'b1;
    src_data[s*PW +: PW]     = mk(s, q);
    if (expect_commit) sbq.push_back({SW'(s), mk(s, q)});
  endtask

  task automatic check_commit(input int nexp, input bit do_pop);
    exp_t e;
    chk("valid", 128'(commit_valid), 128'((1 << nexp) - 1));
    for (int p = 0; p < NP; p++) begin
      e = '0;
      if (p < nexp) begin
        if (do_pop && sbq.size() > 0)      e = sbq.pop_front();
        else if (!do_pop && sbq.size() > p) e = sbq[p];
        else                                 e = 'x;
      end
      chk($sformatf("data%0d", p), 128'(commit_data[p*PW +: PW]), 128'(e.data));
      chk($sformatf("src%0d", p), 128'(commit_src[p*SW +: SW]), 128'(e.src));
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int s);
    return fifo_count[s*CW +: CW];
  endfunction

  initial begin
    reset = 1'b0; flush = 1'b0; src_valid = '0; src_data = '0; commit_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(commit_valid), 0);
    chk("rst_ready", 128'(src_ready), 128'h3f);
    chk("rst_count", 128'(fifo_count), 0);
    chk("rst_data",  128'(commit_data), 0);
    chk("rst_src",   128'(commit_src), 0);
    reset = 1'b1;
    cyc();
    chk("idle_valid", 128'(commit_valid), 0);
    chk("idle_ready", 128'(src_ready), 128'h3f);
    chk("idle_count", 128'(fifo_count), 0);

`ifdef EXEC_ARB_BYPASS_EN
    commit_ready = 1'b1;
    src_valid[3] = 1'b1;
    src_data[3*PW +: PW] = 96'hABC;
    #1;
    chk("byp_valid", 128'(commit_valid), 128'b001);
    chk("byp_data",  128'(commit_data[0 +: PW]), 128'hABC);
    chk("byp_src",   128'(commit_src[0 +: SW]), 3);
    cyc();
    src_valid = '0;
    #1;
    chk("byp_cnt3", 128'(cnt(3)), 0);
    chk("byp_after", 128'(commit_valid), 0);
`else
    // All six sources at once: ports carry 0,1,2 then 3,4,5.
    commit_ready = 1'b1;
    for (int s = 0; s < NS; s++) drive(s, 16 + s, 1'b1);
    #1;
    chk("no_bypass_valid", 128'(commit_valid), 0);
    cyc();
    src_valid = '0;
    #1;
    chk("all_cnt1", 128'(fifo_count), 128'({6{3'd1}}));
    check_commit(3, 1'b1);
    cyc();
    chk("half_cnt", 128'(fifo_count), 128'({3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0}));
    check_commit(3, 1'b1);
    cyc();
    chk("drained_cnt", 128'(fifo_count), 0);
    check_commit(0, 1'b0);

    // Fill source 2 while commit is stalled, overfill, then drain in order.
    commit_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      src_valid = '0;
      drive(2, k, 1'b1);
      #1;
      chk("fill_cnt2", 128'(cnt(2)), 128'(k));
      chk("fill_rdy2", 128'(src_ready[2]), 1);
      cyc();
    end
    drive(2, 4, 1'b0);
    #1;
    chk("full_cnt2", 128'(cnt(2)), 4);
    chk("full_rdy2", 128'(src_ready[2]), 0);
    check_commit(1, 1'b0);
    cyc();
    src_valid = '0;
    #1;
    chk("ovf_cnt2", 128'(cnt(2)), 4);
    commit_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_commit(1, 1'b1);
      chk("drain_cnt2", 128'(cnt(2)), 128'(4 - k));
      cyc();
      #1;
    end
    chk("empty_cnt2", 128'(cnt(2)), 0);

    // Move rr_ptr to 5 via source 4, then sources 1 and 4 compete.
    src_valid = '0;
    drive(4, 64, 1'b1);
    cyc();
    src_valid = '0;
    drive(1, 65, 1'b1);
    drive(4, 66, 1'b1);
    #1;
    check_commit(1, 1'b1);
    cyc();
    src_valid = '0;
    #1;
    check_commit(2, 1'b1);
    cyc();
    drive(5, 81, 1'b1);
    drive(0, 80, 1'b1);
    cyc();
    src_valid = '0;
    #1;
    check_commit(2, 1'b1);
    cyc();

    // Flush with three entries buffered and a push in flight.
    commit_ready = 1'b0;
    drive(0, 96, 1'b0);
    drive(1, 97, 1'b0);
    drive(2, 98, 1'b0);
    cyc();
    src_valid = '0;
    #1;
    chk("pre_flush_valid", 128'(commit_valid), 128'b111);
    flush = 1'b1;
    drive(3, 99, 1'b0);
    #1;
    chk("flush_valid", 128'(commit_valid), 0);
    cyc();
    flush = 1'b0;
    src_valid = '0;
    #1;
    chk("post_flush_cnt", 128'(fifo_count), 0);
    check_commit(0, 1'b0);
    commit_ready = 1'b1;
    drive(0, 112, 1'b1);
    drive(5, 113, 1'b1);
    cyc();
    src_valid = '0;
    #1;
    check_commit(2, 1'b1);
    cyc();

    // Concurrent push and pop on source 3 keeps count and order.
    commit_ready = 1'b0;
    drive(3, 128, 1'b1);
    cyc();
    drive(3, 129, 1'b1);
    cyc();
    commit_ready = 1'b1;
    drive(3, 130, 1'b1);
    #1;
    check_commit(1, 1'b1);
    chk("pp_cnt3", 128'(cnt(3)), 2);
    cyc();
    drive(3, 131, 1'b1);
    #1;
    check_commit(1, 1'b1);
    chk("pp_cnt3", 128'(cnt(3)), 2);
    cyc();
    src_valid = '0;
    #1;
    check_commit(1, 1'b1);
    chk("pp_cnt3", 128'(cnt(3)), 2);
    cyc();
    check_commit(1, 1'b1);
    chk("pp_cnt3", 128'(cnt(3)), 1);
    cyc();
    chk("pp_cnt3", 128'(cnt(3)), 0);
    check_commit(0, 1'b0);

    // Asynchronous reset in mid-cycle discards buffered results.
    commit_ready = 1'b0;
    drive(0, 144, 1'b0);
    drive(1, 145, 1'b0);
    cyc();
    src_valid = '0;
    #1;
    chk("pre_arst_valid", 128'(commit_valid), 128'b011);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_cnt", 128'(fifo_count), 0);
    chk("arst_valid", 128'(commit_valid), 0);
    chk("arst_ready", 128'(src_ready), 128'h3f);
    cyc();
    reset = 1'b1;
    cyc();
    chk("post_arst_valid", 128'(commit_valid), 0);
`endif

    chk("sb_drained", 128'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_commit_arbiter.md
EXEC_COMMIT_ARBITER -- requirements
Module: exec_commit_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 6, number of functional-unit result sources.
REQ-002 SHALL have parameter NUM_PORT, default 3, number of commit ports (1..NUM_SRC).
REQ-003 SHALL have parameter DEPTH, default 4, per-source FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter PAYLOAD_W, default 96, result payload width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port flush  input  1  pipeline flush.
REQ-008 SHALL have port src_valid  input  NUM_SRC  per-source result valid.
REQ-009 SHALL have port src_ready  output  NUM_SRC  per-source FIFO can accept.
REQ-010 SHALL have port src_data  input  NUM_SRC x PAYLOAD_W  per-source payload.
REQ-011 SHALL have port commit_ready  input  1  commit accepts all presented ports this cycle.
REQ-012 SHALL have port commit_valid  output  NUM_PORT  per-port valid.
REQ-013 SHALL have port commit_data  output  NUM_PORT x PAYLOAD_W  per-port payload.
REQ-014 SHALL have port commit_src  output  NUM_PORT x clog2(NUM_SRC)  originating source index.
REQ-015 SHALL have port fifo_count  output  NUM_SRC x clog2(DEPTH+1)  per-source occupancy.

Function
REQ-016 Each source SHALL own a DEPTH-entry FIFO; push when src_valid && src_ready.
REQ-017 src_ready[i] SHALL be 1 iff count[i] < DEPTH (registered, independent of same-cycle pop).
REQ-018 Arbitration SHALL consider only FIFO heads (max one grant per source per cycle).
REQ-019 Up to NUM_PORT non-empty sources SHALL be granted, scanned round-robin from rr_ptr upward, wrapping at NUM_SRC-1 to 0.
REQ-020 Grants SHALL be compacted: k-th granted source drives port k; ports above the grant count show valid 0, data 0, src 0.
REQ-021 Pop of all granted heads SHALL occur only when commit_ready=1; with commit_ready=0 outputs remain presented, no state changes except pushes.
REQ-022 On accepted grant, rr_ptr SHALL become (last granted index + 1) mod NUM_SRC; no grant or commit_ready=0 leaves rr_ptr unchanged.
REQ-023 Simultaneous push and pop on one FIFO SHALL keep count unchanged and preserve order.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-025 flush=1 SHALL force commit_valid=0 that cycle, drop same-cycle pushes, and empty all FIFOs and reset rr_ptr to 0 at the next edge.
REQ-026 Latency without bypass SHALL be 1 cycle: push at edge N visible on commit at cycle N+1.

Reset
REQ-027 While reset=0: all FIFOs empty, rr_ptr=0, commit_valid=0, commit_data=0, commit_src=0, fifo_count=0, src_ready=all 1s.
REQ-028 Reset assertion mid-operation SHALL discard all buffered results immediately (asynchronously).

Configuration
REQ-029 Macro EXEC_ARB_BYPASS_EN defined: a source with empty FIFO and src_valid=1 SHALL be arbitration-eligible the same cycle (0-cycle latency); if granted and commit_ready=1 the result SHALL NOT be written to the FIFO.
REQ-030 EXEC_ARB_BYPASS_EN undefined: only FIFO heads are eligible; latency per REQ-026.

Structure
REQ-031 Shared package SHALL hold payload typedef alias, source-ID width function, and default parameter constants.
REQ-032 One sub-module exec_result_fifo (single-source FIFO with count output) SHALL be instantiated NUM_SRC times; arbiter/compaction stays in top.

Verification
REQ-033 Reset release, no stimulus -> commit_valid=000, src_ready=6'b111111, fifo_count all 0.
REQ-034 Sources 0..5 push once at same edge, commit_ready=1 -> cycle+1 ports carry src 0,1,2; cycle+2 carry 3,4,5; rr_ptr then 0.
REQ-035 Source 2 pushes 4 results with commit_ready=0 -> count=4, src_ready[2]=0; 5th push ignored; after commit_ready=1 results drain in push order.
REQ-036 Only sources 1 and 4 non-empty, rr_ptr=5 -> port0=src 1, port1=src 4, port2 valid 0; rr_ptr becomes 5.
REQ-037 flush with 3 entries buffered and push asserted -> commit_valid=0 that cycle; next cycle all counts 0, no output.
REQ-038 EXEC_ARB_BYPASS_EN defined, empty FIFOs, src 3 valid with payload 0xABC, commit_ready=1 -> same cycle port0 data 0xABC src 3; fifo_count[3] stays 0.
